// File: rtl/s_mem_phase_sequencer.sv
// s_mem_phase_sequencer: runs init/shuffle/decrypt clients in order, owns the S-memory bus, watchdogs each phase
module s_mem_phase_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        phase,
    output logic              start_init,
    output logic              start_shuffle,
    output logic              start_decrypt,
    input  logic              finish_init,
    input  logic              finish_shuffle,
    input  logic              finish_decrypt,
    input  logic [ADDR_W-1:0] addr_init,
    input  logic [ADDR_W-1:0] addr_shuffle,
    input  logic [ADDR_W-1:0] addr_decrypt,
    input  logic [DATA_W-1:0] data_init,
    input  logic [DATA_W-1:0] data_shuffle,
    input  logic [DATA_W-1:0] data_decrypt,
    input  logic              wren_init,
    input  logic              wren_shuffle,
    input  logic              wren_decrypt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SHUFFLE, S_DECRYPT, S_DONE, S_ERROR} state_t;

    state_t           state;
    logic [CNT_W-1:0] wdog;
    logic             fin;

    always_comb begin
        start_init    = state == S_INIT;
        start_shuffle = state == S_SHUFFLE;
        start_decrypt = state == S_DECRYPT;
        busy          = start_init | start_shuffle | start_decrypt;
        done          = state == S_DONE;
        error         = state == S_ERROR;
        phase         = start_init ? 2'd1 : start_shuffle ? 2'd2 : start_decrypt ? 2'd3 : 2'd0;
        fin           = start_init ? finish_init : start_shuffle ? finish_shuffle : start_decrypt & finish_decrypt;
        mem_addr      = start_init ? addr_init : start_shuffle ? addr_shuffle : start_decrypt ? addr_decrypt : '0;
        mem_data      = start_init ? data_init : start_shuffle ? data_shuffle : start_decrypt ? data_decrypt : '0;
        mem_wren      = start_init ? wren_init : start_shuffle ? wren_shuffle : start_decrypt & wren_decrypt;
    end

    // finish is tested before the timeout so a finish on the last allowed cycle wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            wdog  <= '0;
        end else if (!busy) begin
            wdog <= '0;
            if (start) state <= S_INIT;
        end else if (fin) begin
            wdog  <= '0;
            state <= start_init ? S_SHUFFLE : start_shuffle ? S_DECRYPT : S_DONE;
        end else if (wdog == LAST) begin
            wdog  <= '0;
            state <= S_ERROR;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
endmodule

// File: tb/tb_s_mem_phase_sequencer.sv
// tb_s_mem_phase_sequencer: randomized bench checking two sequencer instances against a phase-level model
module tb_s_mem_phase_sequencer;
    logic       clk = 0, reset = 0, start = 0;
    logic       fin [1:3];
    logic [7:0] ca [1:3], cd [1:3];
    logic       cw [1:3];
    logic       busy_o [2], done_o [2], error_o [2], mw_o [2];
    logic [1:0] phase_o [2];
    logic [3:1] st_o [2];
    logic [7:0] ma_o [2], md_o [2];
    int         checks = 0, errors = 0;
    int         ms [2], mage [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        s_mem_phase_sequencer #(.TIMEOUT_CYCLES(g ? 16 : 4096)) u (
            .clk(clk), .reset(reset), .start(start),
            .busy(busy_o[g]), .done(done_o[g]), .error(error_o[g]), .phase(phase_o[g]),
            .start_init(st_o[g][1]), .start_shuffle(st_o[g][2]), .start_decrypt(st_o[g][3]),
            .finish_init(fin[1]), .finish_shuffle(fin[2]), .finish_decrypt(fin[3]),
            .addr_init(ca[1]), .addr_shuffle(ca[2]), .addr_decrypt(ca[3]),
            .data_init(cd[1]), .data_shuffle(cd[2]), .data_decrypt(cd[3]),
            .wren_init(cw[1]), .wren_shuffle(cw[2]), .wren_decrypt(cw[3]),
            .mem_addr(ma_o[g]), .mem_data(md_o[g]), .mem_wren(mw_o[g])
        );
    end

    function automatic int tmo(int k);
        return k ? 16 : 4096;
    endfunction

    // model: ms 0=idle 1..3=phase 4=done 5=error, mage = cycles spent in current phase
    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                ms[k] = 0;
                mage[k] = 0;
            end else if (ms[k] == 0 || ms[k] >= 4) begin
                if (start) begin
                    ms[k] = 1;
                    mage[k] = 0;
                end
            end else if (fin[ms[k]]) begin
                ms[k] = ms[k] == 3 ? 4 : ms[k] + 1;
                mage[k] = 0;
            end else if (mage[k] == tmo(k) - 1) begin
                ms[k] = 5;
                mage[k] = 0;
            end else begin
                mage[k]++;
            end
        end
    end

    function automatic logic [24:0] expv(int k);
        int s, j;
        logic b;
        s = ms[k];
        b = s >= 1 && s <= 3;
        j = b ? s : 1;
        return {b, s == 4, s == 5, b ? 2'(s) : 2'd0, s == 3, s == 2, s == 1,
                b ? cw[j] : 1'b0, b ? ca[j] : 8'h0, b ? cd[j] : 8'h0};
    endfunction

    function automatic logic [24:0] actv(int k);
        return {busy_o[k], done_o[k], error_o[k], phase_o[k], st_o[k], mw_o[k], ma_o[k], md_o[k]};
    endfunction

    task automatic do_reset;
        reset = 0;
        start = 0;
        for (int p = 1; p <= 3; p++) begin
            fin[p] = 0;
            ca[p] = 0;
            cd[p] = 0;
            cw[p] = 0;
        end
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        reset = 0;
        for (int p = 1; p <= 3; p++) begin
            ca[p] = 8'($urandom);
            cd[p] = 8'($urandom);
            cw[p] = 1;
        end
        start = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (actv(k) !== 25'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %h expected %h", k, actv(k), 25'h0);
            end
        end
        start = 0;
        reset = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (actv(k) !== 25'h0) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d: got %h expected %h", k, actv(k), 25'h0);
            end
        end
    endtask

    task automatic test_sequence(input string name, input int l1, input int l2, input int l3,
                                 input bit fixed, input bit stale, input bit poke);
        int lat [1:3];
        int cnt [1:3];
        int seen [$];
        int c, last;
        bit got;
        do_reset;
        lat[1] = l1;
        lat[2] = l2;
        lat[3] = l3;
        for (int p = 1; p <= 3; p++) cnt[p] = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        c = 1;
        last = 0;
        got = 0;
        while (!got && c <= 1 + l1 + l2 + l3 + 4) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (actv(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, c, actv(k), expv(k));
                end
            end
            for (int p = 1; p <= 3; p++) if (st_o[0][p]) cnt[p]++;
            if (phase_o[0] != 0 && int'(phase_o[0]) != last) seen.push_back(int'(phase_o[0]));
            last = int'(phase_o[0]);
            got = done_o[0];
            for (int p = 1; p <= 3; p++) begin
                fin[p] = (st_o[0][p] || (stale && p == 1)) && cnt[p] == lat[p];
                ca[p] = fixed ? 8'(p * 17) : 8'($urandom);
                cd[p] = 8'($urandom);
                cw[p] = fixed ? 1'b1 : 1'($urandom);
            end
            start = poke && busy_o[0] ? 1'($urandom) : 1'b0;
            if (!got) begin
                @(negedge clk);
                c++;
            end
        end
        start = 0;
        checks++;
        if (!got || c != 1 + l1 + l2 + l3) begin
            errors++;
            $display("FAIL %s run_length: got done=%0b at cycle %0d expected cycle %0d", name, got, c, 1 + l1 + l2 + l3);
        end
        for (int p = 1; p <= 3; p++) begin
            checks++;
            if (cnt[p] != lat[p]) begin
                errors++;
                $display("FAIL %s start_window phase %0d: got %0d cycles expected %0d", name, p, cnt[p], lat[p]);
            end
        end
        checks++;
        if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
            errors++;
            $display("FAIL %s phase_order: got %p expected 1,2,3", name, seen);
        end
    endtask

    task automatic test_watchdog;
        do_reset;
        start = 1;
        fin[1] = 1;
        cw[2] = 1;
        ca[2] = 8'h22;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        fin[1] = 0;
        checks++;
        if (phase_o[1] !== 2'd2) begin
            errors++;
            $display("FAIL wd_enter_shuffle: got phase %0d expected 2", phase_o[1]);
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (error_o[1] !== (i == 16) || phase_o[1] !== (i == 16 ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL wd_timeout cycle %0d: got error=%0b phase=%0d expected error=%0b", i, error_o[1], phase_o[1], i == 16);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error_o[1] !== 1 || st_o[1] !== 3'b000 || busy_o[1] !== 0 || mw_o[1] !== 0 || ma_o[1] !== 8'h0) begin
            errors++;
            $display("FAIL wd_sticky_error: got error=%0b starts=%b busy=%0b wren=%0b addr=%h expected 1,000,0,0,00",
                     error_o[1], st_o[1], busy_o[1], mw_o[1], ma_o[1]);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (phase_o[1] !== 2'd1 || error_o[1] !== 0 || st_o[1] !== 3'b001) begin
            errors++;
            $display("FAIL wd_restart: got phase=%0d error=%0b starts=%b expected 1,0,001", phase_o[1], error_o[1], st_o[1]);
        end
        checks++;
        if (phase_o[0] !== 2'd2) begin
            errors++;
            $display("FAIL busy_ignores_start: got phase %0d expected 2", phase_o[0]);
        end
    endtask

    task automatic test_edge_race;
        do_reset;
        start = 1;
        fin[1] = 1;
        fin[2] = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        fin[1] = 0;
        fin[2] = 0;
        checks++;
        if (phase_o[1] !== 2'd3) begin
            errors++;
            $display("FAIL race_enter_decrypt: got phase %0d expected 3", phase_o[1]);
        end
        for (int i = 1; i <= 15; i++) begin
            start = 1'($urandom);
            @(negedge clk);
            checks++;
            if (phase_o[1] !== 2'd3 || error_o[1] !== 0) begin
                errors++;
                $display("FAIL race_hold cycle %0d: got phase=%0d error=%0b expected 3,0", i, phase_o[1], error_o[1]);
            end
        end
        fin[3] = 1;
        start = 1;
        @(negedge clk);
        fin[3] = 0;
        start = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (done_o[k] !== 1 || error_o[k] !== 0 || phase_o[k] !== 2'd0) begin
                errors++;
                $display("FAIL race_finish_wins dut%0d: got done=%0b error=%0b phase=%0d expected 1,0,0", k, done_o[k], error_o[k], phase_o[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (done_o[1] !== 1) begin
            errors++;
            $display("FAIL done_sticky: got %0b expected 1", done_o[1]);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        start = 1;
        fin[1] = 1;
        cw[2] = 1;
        ca[2] = 8'h5a;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        fin[1] = 0;
        checks++;
        if (mw_o[0] !== 1 || st_o[0] !== 3'b010 || ma_o[0] !== 8'h5a) begin
            errors++;
            $display("FAIL async_pre: got wren=%0b starts=%b addr=%h expected 1,010,5a", mw_o[0], st_o[0], ma_o[0]);
        end
        #2 reset = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (mw_o[k] !== 0 || st_o[k] !== 3'b000 || busy_o[k] !== 0) begin
                errors++;
                $display("FAIL async_drop dut%0d: got wren=%0b starts=%b busy=%0b expected 0,000,0", k, mw_o[k], st_o[k], busy_o[k]);
            end
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (actv(k) !== 25'h0) begin
                errors++;
                $display("FAIL async_idle dut%0d: got %h expected %h", k, actv(k), 25'h0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_sequence("nominal", 256, 768, 64, 1, 0, 0);
        repeat (4) test_sequence("random", $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40), 0, 0, 1);
        test_sequence("stale", $urandom_range(2, 20), $urandom_range(20, 60), $urandom_range(1, 20), 0, 1, 0);
        test_watchdog;
        test_edge_race;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/s_mem_phase_sequencer.md
Name: s_mem_phase_sequencer

Overview:
- Top-level sequencer and bus owner for the single-port S working memory (256x8) in the RC4 key-schedule/decrypt design.
- Runs three client FSMs in fixed order: init (S[i]=i), shuffle (key schedule), decrypt. Uses a start/finish handshake with each client.
- Only the active client drives the S-memory address/data/write-enable bus.
- A per-phase watchdog flags a hung client.

Parameters:
- ADDR_W, 8, S-memory address width
- DATA_W, 8, S-memory data width
- TIMEOUT_CYCLES, 4096, max cycles a phase may run before error; must be >= 2

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  run request, sampled in IDLE/DONE/ERROR only
- busy  out  1  high in INIT, SHUFFLE, DECRYPT
- done  out  1  high in DONE
- error  out  1  high in ERROR
- phase  out  2  0=idle/done/error, 1=init, 2=shuffle, 3=decrypt
- start_init / start_shuffle / start_decrypt  out  1 each  client start, level
- finish_init / finish_shuffle / finish_decrypt  in  1 each  client completion
- addr_init, addr_shuffle, addr_decrypt  in  ADDR_W each  client addresses
- data_init, data_shuffle, data_decrypt  in  DATA_W each  client write data
- wren_init, wren_shuffle, wren_decrypt  in  1 each  client write enables
- mem_addr  out  ADDR_W  to s_memory address
- mem_data  out  DATA_W  to s_memory data
- mem_wren  out  1  to s_memory wren

Behaviour:
- States: IDLE, INIT, SHUFFLE, DECRYPT, DONE, ERROR. The state register is the only sequential control. All outputs except the watchdog counter decode combinationally from the state.
- Reset (reset=0, async):
  - state=IDLE, watchdog counter=0.
  - Hence busy=0, done=0, error=0, phase=0, all start_x=0.
  - mem_addr=0, mem_data=0, mem_wren=0.
- IDLE/DONE/ERROR: start=1 at a clock edge -> INIT next cycle. Leaving DONE clears done; leaving ERROR clears error.
- INIT:
  - start_init=1.
  - finish_init=1 at an edge -> SHUFFLE.
- SHUFFLE:
  - start_shuffle=1.
  - finish_shuffle=1 -> DECRYPT.
- DECRYPT:
  - start_decrypt=1.
  - finish_decrypt=1 -> DONE.
- Exactly one start_x is high in a busy state; all are 0 otherwise. start_x drops the cycle after its finish is sampled. The next start_x rises in that same cycle.
- finish_x is sampled only in its own phase. Finish inputs of non-active clients are ignored, including a still-high finish from the previous phase.
- start is ignored while busy.
- Bus mux, zero latency (combinational from state):
  - mem_addr/mem_data/mem_wren = the active client's addr/data/wren.
  - In IDLE/DONE/ERROR: all bus outputs are 0.
  - Inactive clients' wren never reach mem_wren.
  - Read data q from s_memory is wired directly to all clients. It is not routed here.
- Watchdog:
  - Counter (width ceil(log2(TIMEOUT_CYCLES))) clears on every phase entry.
  - It increments each cycle in INIT/SHUFFLE/DECRYPT.
  - If it equals TIMEOUT_CYCLES-1 at an edge with no finish for the active phase -> ERROR.
  - Simultaneous finish and timeout at the same edge: finish wins.
  - Counter holds at 0 in IDLE/DONE/ERROR.
- ERROR is sticky until start or reset. Restart from ERROR or DONE always begins at INIT. There is no resume.
- Reset mid-phase: immediate return to IDLE. start_x and mem_wren go 0 asynchronously, so no write completes after reset assertion.
- Nominal latency: start edge -> busy at +1 cycle. Total run = 1 + T_init + T_shuffle + T_decrypt cycles, where T_x = cycles from start_x rise to finish_x sampled.

Test Plan:
- Reset then start pulse. Client models finish after 256, 768, 64 cycles -> phase sequence 1,2,3. done=1 exactly 1089 cycles after the start edge. Each start_x is high for exactly its window.
- Bus isolation: all three clients drive wren=1 with addr = 0x11/0x22/0x33 -> mem_addr follows only the active client. mem_wren=0 in IDLE and DONE.
- Stale finish: finish_init held high through SHUFFLE -> no skip. SHUFFLE lasts until finish_shuffle.
- Watchdog with TIMEOUT_CYCLES=16: shuffle never finishes -> ERROR 16 cycles after SHUFFLE entry. error=1, all start_x=0. A start pulse then reruns from INIT.
- Edge race: finish_decrypt asserted on the timeout cycle -> DONE, not ERROR. start pulses during busy produce no state change.
- Async reset asserted mid-SHUFFLE with wren_shuffle=1 -> mem_wren and start_shuffle drop before the next clk edge. State is IDLE after release.
